// File: rtl/hybridcache_req_arbiter.sv
// Four-way round-robin request scheduler with near-full warning priority.
// Holds a single outstanding request on the downstream memory port.
module hybridcache_req_arbiter #(
   parameter int REQBITS = 64
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 arb_enable,
   input  logic [4*REQBITS-1:0] q_data,
   input  logic [3:0]           q_not_empty,
   input  logic [3:0]           q_warning,
   output logic [3:0]           q_pop,
   output logic                 mem_req,
   output logic [REQBITS-1:0]   mem_req_data,
   output logic [1:0]           mem_req_id,
   input  logic                 mem_ack,
   output logic                 busy
);

   typedef enum logic {
      IDLE = 1'b0,
      REQ  = 1'b1
   } state_t;

   state_t               state_reg, state_next;
   logic [1:0]           last_grant_reg;
   logic                 mem_req_reg;
   logic                 busy_reg;
   logic [REQBITS-1:0]   mem_req_data_reg;
   logic [1:0]           mem_req_id_reg;

   logic [3:0]           warn_cand;
   logic [3:0]           cand;
   logic [3:0]           rot_cand;
   logic [1:0]           sel_off;
   logic [1:0]           sel_idx;
   logic                 grant;
   logic [REQBITS-1:0]   q_slice [4];

   // A warning on an empty queue is meaningless, so mask it first.
   assign warn_cand = q_not_empty & q_warning;
   assign cand      = (warn_cand != 4'b0000) ? warn_cand : q_not_empty;

   // rot_cand[i] is the candidate bit of queue last_grant+1+i.
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_slot
         localparam logic [1:0] OFF = 2'(gi + 1);
         assign q_slice[gi]  = q_data[gi*REQBITS +: REQBITS];
         assign rot_cand[gi] = cand[last_grant_reg + OFF];
      end
   endgenerate

   always_comb begin
      sel_off = 2'd3;
      if (rot_cand[0])      sel_off = 2'd0;
      else if (rot_cand[1]) sel_off = 2'd1;
      else if (rot_cand[2]) sel_off = 2'd2;
   end

   assign sel_idx = last_grant_reg + sel_off + 2'd1;

   // A new grant needs the port free or freeing this edge.
   assign grant = reset_n && arb_enable && (cand != 4'b0000) &&
                  ((state_reg == IDLE) || mem_ack);

   assign q_pop = grant ? (4'b0001 << sel_idx) : 4'b0000;

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: begin
            if (grant) state_next = REQ;
         end
         REQ: begin
            if (mem_ack && !grant) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg        <= IDLE;
         last_grant_reg   <= 2'd3;
         mem_req_reg      <= 1'b0;
         busy_reg         <= 1'b0;
         mem_req_data_reg <= '0;
         mem_req_id_reg   <= 2'd0;
      end else begin
         state_reg <= state_next;
         if (grant) begin
            last_grant_reg   <= sel_idx;
            mem_req_reg      <= 1'b1;
            busy_reg         <= 1'b1;
            mem_req_data_reg <= q_slice[sel_idx];
            mem_req_id_reg   <= sel_idx;
         end else if ((state_reg == REQ) && mem_ack) begin
            mem_req_reg <= 1'b0;
            busy_reg    <= 1'b0;
         end
      end
   end

   assign mem_req      = mem_req_reg;
   assign busy         = busy_reg;
   assign mem_req_data = mem_req_data_reg;
   assign mem_req_id   = mem_req_id_reg;

endmodule

// File: tb/tb_hybridcache_req_arbiter.sv
// Randomized bench for hybridcache_req_arbiter: FIFO-backed queues and a
// transaction-level reference model of the grant rules.
module tb_hybridcache_req_arbiter;
   localparam int RB = 64;

   logic            clk = 1'b0;
   logic            reset_n;
   logic            arb_enable;
   logic [4*RB-1:0] q_data;
   logic [3:0]      q_not_empty;
   logic [3:0]      q_warning;
   logic [3:0]      q_pop;
   logic            mem_req;
   logic [RB-1:0]   mem_req_data;
   logic [1:0]      mem_req_id;
   logic            mem_ack;
   logic            busy;

   always #5 clk = ~clk;

   hybridcache_req_arbiter #(.REQBITS(RB)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .arb_enable   (arb_enable),
      .q_data       (q_data),
      .q_not_empty  (q_not_empty),
      .q_warning    (q_warning),
      .q_pop        (q_pop),
      .mem_req      (mem_req),
      .mem_req_data (mem_req_data),
      .mem_req_id   (mem_req_id),
      .mem_ack      (mem_ack),
      .busy         (busy)
   );

   logic [63:0] fifo [4][$];
   int total = 0;
   int bad   = 0;
   int unsigned p_push, p_warn, p_en, p_ack;
   int pend = -1;

   // reference model: the request currently presented downstream
   bit          m_req;
   logic [63:0] m_data;
   int          m_id;
   int          m_last;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_req  = 1'b0;
      m_data = '0;
      m_id   = 0;
      m_last = 3;
      pend   = -1;
   endtask

   // One cycle, entered at the falling edge.
   task automatic step();
      logic [3:0] ne, w, c, exp_pop;
      int k;
      if (pend >= 0) begin
         void'(fifo[pend].pop_front());
         pend = -1;
      end
      for (int q = 0; q < 4; q++) begin
         if (fifo[q].size() < 4 && $urandom_range(99) < p_push)
            fifo[q].push_back({$urandom, $urandom});
         ne[q] = fifo[q].size() > 0;
         q_data[q*RB +: RB] = ne[q] ? fifo[q][0] : '0;
         w[q] = $urandom_range(99) < p_warn;
      end
      q_not_empty = ne;
      q_warning   = w;
      arb_enable  = $urandom_range(99) < p_en;
      mem_ack     = $urandom_range(99) < p_ack;
      #1;
      c = ((ne & w) != 4'b0000) ? (ne & w) : ne;
      k = -1;
      if (arb_enable && c != 4'b0000 && (!m_req || mem_ack)) begin
         for (int j = 1; j <= 4; j++) begin
            int idx;
            idx = (m_last + j) % 4;
            if (k < 0 && c[idx]) k = idx;
         end
      end
      exp_pop = (k >= 0) ? 4'(1 << k) : 4'b0000;
      check_val("q_pop",   64'(q_pop),      64'(exp_pop));
      check_val("mem_req", 64'(mem_req),    64'(m_req));
      check_val("busy",    64'(busy),       64'(m_req));
      check_val("req_id",  64'(mem_req_id), 64'(m_id));
      check_val("req_data", mem_req_data,   m_data);
      if (k >= 0) begin
         m_req  = 1'b1;
         m_data = fifo[k][0];
         m_id   = k;
         m_last = k;
         pend   = k;
         $display("grant q%0d data=%h", k, m_data);
      end else if (m_req && mem_ack) begin
         m_req = 1'b0;
      end
   endtask

   task automatic reset_pulse();
      @(negedge clk);
      if (pend >= 0) begin
         void'(fifo[pend].pop_front());
         pend = -1;
      end
      reset_n = 1'b0;
      #1;
      check_val("rst_mem_req", 64'(mem_req),    64'd0);
      check_val("rst_busy",    64'(busy),       64'd0);
      check_val("rst_id",      64'(mem_req_id), 64'd0);
      check_val("rst_data",    mem_req_data,    64'd0);
      check_val("rst_q_pop",   64'(q_pop),      64'd0);
      model_reset();
      @(negedge clk);
      reset_n = 1'b1;
      step();
   endtask

   task automatic run_phase(input int cycles, input bit with_reset);
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         step();
         if (with_reset && m_req && (i % 37 == 0)) reset_pulse();
      end
   endtask

   initial begin
      reset_n    = 1'b0;
      arb_enable = 1'b1;
      mem_ack    = 1'b0;
      q_warning  = 4'b0000;
      for (int q = 0; q < 4; q++) begin
         fifo[q].push_back({$urandom, $urandom});
         fifo[q].push_back({$urandom, $urandom});
         q_data[q*RB +: RB] = fifo[q][0];
      end
      q_not_empty = 4'b1111;
      #12;
      check_val("init_q_pop",   64'(q_pop),      64'd0);
      check_val("init_mem_req", 64'(mem_req),    64'd0);
      check_val("init_busy",    64'(busy),       64'd0);
      check_val("init_id",      64'(mem_req_id), 64'd0);
      check_val("init_data",    mem_req_data,    64'd0);
      model_reset();

      // mixed traffic with warnings, wait states and enable gaps
      p_push = 40; p_warn = 20; p_en = 85; p_ack = 50;
      @(negedge clk);
      reset_n = 1'b1;
      step();
      run_phase(300, 1'b0);

      // sustained round-robin: queues always full, ack tied high
      p_push = 100; p_warn = 0; p_en = 100; p_ack = 100;
      run_phase(40, 1'b0);

      // long wait states with asynchronous resets mid-request
      p_push = 50; p_warn = 30; p_en = 90; p_ack = 25;
      run_phase(250, 1'b1);

      // heavy enable gating
      p_push = 60; p_warn = 40; p_en = 30; p_ack = 60;
      run_phase(200, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
